microprogram_sequencer: RTL and testbench

//  Drives the 7-bit state address into the control unit's microstore and decides it each cycle.
//  The microstore returns next-state control fields: N (3b), S (2b), Inv (1b) and CR (7b literal).
//  The sequencer combines those fields with datapath status and produces the next state.

---
 rtl/microprogram_sequencer_pkg.sv | 31 +++
 rtl/microprogram_sequencer_condition_selector.sv | 37 +++
 rtl/microprogram_sequencer.sv | 123 ++++++++++++
 tb/tb_microprogram_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/microprogram_sequencer_pkg.sv
// Shared constants for the microprogram sequencer: state width, reset state,
// next-state (N-field) and condition-select (S-field) encodings.
package microprogram_sequencer_pkg;

  // Width of the microstore state address.
  localparam int STATE_W = 7;

  // State loaded by reset.
  localparam logic [STATE_W-1:0] RESET_STATE = 7'd0;

  // Next-state select codes carried in the microstore N field.
  typedef enum logic [2:0] {
    NS_DECODE = 3'b000,  // go to instruction decoder entry state
    NS_INC    = 3'b001,  // sequential step
    NS_JUMP   = 3'b010,  // unconditional branch to literal
    NS_CBR    = 3'b011,  // conditional branch to literal, else step
    NS_CDEC   = 3'b100,  // conditional branch to literal, else decode
    NS_WAIT   = 3'b101,  // hold until condition, then step
    NS_CALL   = 3'b110,  // branch to literal, remember return point
    NS_RET    = 3'b111   // return to remembered point
  } ns_code_e;

  // Condition select codes carried in the microstore S field.
  typedef enum logic [1:0] {
    CS_MOC  = 2'b00,  // memory operation complete
    CS_ZERO = 2'b01,  // ALU zero flag
    CS_COND = 2'b10,  // branch condition result
    CS_ONE  = 2'b11   // constant true
  } cs_code_e;

endpackage : microprogram_sequencer_pkg

// File: rtl/microprogram_sequencer_condition_selector.sv
// Combinational condition selector: picks one status bit by the S field and
// optionally inverts it, producing the branch/wait condition c.
module condition_selector
  import microprogram_sequencer_pkg::*;
(
  input  logic [1:0] sField,
  input  logic       invField,
  input  logic       moc,
  input  logic       zero,
  input  logic       cond,
  output logic       c
);

  logic sel_w;

  // Select the raw status bit; an unknown select yields a false condition.
  always_comb begin
    sel_w = 1'b0;
    case (sField)
      CS_MOC:  sel_w = moc;
      CS_ZERO: sel_w = zero;
      CS_COND: sel_w = cond;
      CS_ONE:  sel_w = 1'b1;
      default: sel_w = 1'b0;
    endcase
  end

  // Apply the invert bit; an unknown invert bit passes the raw condition.
  always_comb begin
    if (invField) begin
      c = ~sel_w;
    end else begin
      c = sel_w;
    end
  end

endmodule : condition_selector

// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: computes and registers the next microstore state
// from the microstore control fields and datapath status. Holds a one-entry
// return register for CALL/RET and a timeout counter that forces a fault
// state when a WAIT holds too long.
module microprogram_sequencer
  import microprogram_sequencer_pkg::*;
#(
  parameter int                 STATE_W     = microprogram_sequencer_pkg::STATE_W,
  parameter int                 MOC_TIMEOUT = 16,
  parameter logic [STATE_W-1:0] FAULT_STATE = {STATE_W{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         nField,
  input  logic [1:0]         sField,
  input  logic               invField,
  input  logic [STATE_W-1:0] crField,
  input  logic [STATE_W-1:0] encoderState,
  input  logic               moc,
  input  logic               zero,
  input  logic               cond,
  output logic [STATE_W-1:0] currentState,
  output logic               waiting,
  output logic               fault
);

  // Counter wide enough to hold 0 .. MOC_TIMEOUT-1.
  localparam int CNT_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STATE_W-1:0] STATE_ONE = STATE_W'(1);
  localparam logic [STATE_W-1:0] STATE_RST = STATE_W'(RESET_STATE);

  logic               c_w;
  logic [STATE_W-1:0] inc_state_w;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q,   ret_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fault_q, fault_d;

  condition_selector u_cond_sel (
    .sField   (sField),
    .invField (invField),
    .moc      (moc),
    .zero     (zero),
    .cond     (cond),
    .c        (c_w)
  );

  // Sequential successor; natural wrap at the top of the state space.
  assign inc_state_w = state_q + STATE_ONE;

  // Next-state mux, return register update and wait-timeout bookkeeping.
  // Anything other than a holding WAIT clears the timeout counter; an unknown
  // N field falls to the default arm and behaves like INC.
  always_comb begin
    state_d    = inc_state_w;
    ret_d      = ret_q;
    wait_cnt_d = '0;
    fault_d    = 1'b0;
    case (nField)
      NS_DECODE: state_d = encoderState;
      NS_INC:    state_d = inc_state_w;
      NS_JUMP:   state_d = crField;
      NS_CBR: begin
        if (c_w) begin
          state_d = crField;
        end else begin
          state_d = inc_state_w;
        end
      end
      NS_CDEC: begin
        if (c_w) begin
          state_d = crField;
        end else begin
          state_d = encoderState;
        end
      end
      NS_WAIT: begin
        if (c_w) begin
          // Condition satisfied: advance, even on the would-be timeout cycle.
          state_d = inc_state_w;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Held too long: escape to the fault handler.
          state_d = FAULT_STATE;
          fault_d = 1'b1;
        end else begin
          state_d    = state_q;
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      NS_CALL: begin
        state_d = crField;
        ret_d   = inc_state_w;
      end
      NS_RET:  state_d = ret_q;
      default: state_d = inc_state_w;
    endcase
  end

  // State, return register, timeout counter and fault pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= STATE_RST;
      ret_q      <= STATE_RST;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign currentState = state_q;
  assign fault        = fault_q;

  // Unsatisfied wait in the current cycle; forced low while in reset.
  assign waiting = (nField == NS_WAIT) & ~c_w & ~reset;

endmodule : microprogram_sequencer

// File: tb/tb_microprogram_sequencer.sv
// Scoreboard bench for microprogram_sequencer: a behavioural model predicts
// each post-edge state, fault and waiting value; a monitor compares them.
module tb_microprogram_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] nField;
  logic [1:0] sField;
  logic       invField;
  logic [6:0] crField;
  logic [6:0] encoderState;
  logic       moc, zero, cond;
  logic [6:0] currentState;
  logic       waiting, fault;

  microprogram_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .nField       (nField),
    .sField       (sField),
    .invField     (invField),
    .crField      (crField),
    .encoderState (encoderState),
    .moc          (moc),
    .zero         (zero),
    .cond         (cond),
    .currentState (currentState),
    .waiting      (waiting),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit flt;
    bit wt;
    bit hand;
    int hst;
    bit hflt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_st  = 0;
  int m_ret = 0;
  int m_wc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of fields, predict the outcome, queue it, advance to posedge+2.
  task automatic cyc(input int n, input int s, input int inv, input int cr,
                     input int enc, input int mo, input int ze, input int co,
                     input bit hand = 1'b0, input int hst = 0, input bit hflt = 1'b0);
    exp_t e;
    int sel, c, nxt;
    bit f;
    nField = n[2:0]; sField = s[1:0]; invField = inv[0];
    crField = cr[6:0]; encoderState = enc[6:0];
    moc = mo[0]; zero = ze[0]; cond = co[0];
    case (s)
      0: sel = mo;
      1: sel = ze;
      2: sel = co;
      default: sel = 1;
    endcase
    c = (sel + inv) % 2;
    f = 1'b0;
    e.wt = (n == 5) && (c == 0);
    case (n)
      0: nxt = enc;
      2: nxt = cr;
      3: nxt = c ? cr : (m_st + 1) % 128;
      4: nxt = c ? cr : enc;
      5: begin
        if (c != 0) begin
          nxt = (m_st + 1) % 128; m_wc = 0;
        end else if (m_wc == 15) begin
          nxt = 127; f = 1'b1; m_wc = 0;
        end else begin
          nxt = m_st; m_wc = m_wc + 1;
        end
      end
      6: begin m_ret = (m_st + 1) % 128; nxt = cr; end
      7: nxt = m_ret;
      default: nxt = (m_st + 1) % 128;
    endcase
    if (n != 5) m_wc = 0;
    m_st = nxt;
    e.st = nxt; e.flt = f; e.hand = hand; e.hst = hst; e.hflt = hflt;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: after each edge, compare DUT outputs with the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("state", int'(currentState), e.st);
        chk("fault", int'(fault), int'(e.flt));
        chk("waiting", int'(waiting), int'(e.wt));
        if (e.hand) begin
          chk("hand_state", int'(currentState), e.hst);
          chk("hand_fault", int'(fault), int'(e.hflt));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    nField = 3'd0; sField = 2'd0; invField = 1'b0;
    crField = 7'd0; encoderState = 7'd0;
    moc = 1'b0; zero = 1'b0; cond = 1'b0;
    #1;
    chk("reset_state", int'(currentState), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_waiting", int'(waiting), 0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;

    // RET before any CALL returns to 0.
    cyc(7, 3, 0, 55, 0, 0, 0, 0, 1'b1, 0, 1'b0);

    // INC wrap and DECODE.
    cyc(2, 3, 0, 126, 0, 0, 0, 0, 1'b1, 126, 1'b0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 1'b1, 127, 1'b0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);
    cyc(0, 3, 0, 0, 9, 0, 0, 0, 1'b1, 9, 1'b0);

    // CBR on zero flag, plain and inverted.
    cyc(2, 3, 0, 3, 0, 0, 0, 0, 1'b1, 3, 1'b0);
    cyc(3, 1, 0, 40, 0, 0, 1, 0, 1'b1, 40, 1'b0);
    cyc(3, 1, 1, 40, 0, 0, 1, 0, 1'b1, 41, 1'b0);
    // CDEC falls to decode when condition false.
    cyc(4, 2, 0, 77, 12, 0, 0, 0, 1'b1, 12, 1'b0);

    // WAIT on MOC: three holds then advance.
    cyc(2, 3, 0, 50, 0, 0, 0, 0, 1'b1, 50, 1'b0);
    for (int i = 0; i < 3; i++) cyc(5, 0, 0, 0, 0, 0, 0, 0, 1'b1, 50, 1'b0);
    cyc(5, 0, 0, 0, 0, 1, 0, 0, 1'b1, 51, 1'b0);

    // WAIT timeout: 16th holding edge goes to 127 with a one-cycle fault.
    cyc(2, 3, 0, 60, 0, 0, 0, 0, 1'b1, 60, 1'b0);
    for (int i = 0; i < 15; i++) cyc(5, 0, 0, 0, 0, 0, 0, 0, 1'b1, 60, 1'b0);
    cyc(5, 0, 0, 0, 0, 0, 0, 0, 1'b1, 127, 1'b1);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);
    // MOC arrives on the 16th cycle: condition wins, no fault.
    cyc(2, 3, 0, 70, 0, 0, 0, 0, 1'b1, 70, 1'b0);
    for (int i = 0; i < 15; i++) cyc(5, 0, 0, 0, 0, 0, 0, 0, 1'b1, 70, 1'b0);
    cyc(5, 0, 0, 0, 0, 1, 0, 0, 1'b1, 71, 1'b0);

    // CALL / RET, including nested overwrite.
    cyc(2, 3, 0, 10, 0, 0, 0, 0, 1'b1, 10, 1'b0);
    cyc(6, 3, 0, 20, 0, 0, 0, 0, 1'b1, 20, 1'b0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 1'b1, 21, 1'b0);
    cyc(7, 3, 0, 0, 0, 0, 0, 0, 1'b1, 11, 1'b0);
    cyc(2, 3, 0, 30, 0, 0, 0, 0, 1'b1, 30, 1'b0);
    cyc(6, 3, 0, 35, 0, 0, 0, 0, 1'b1, 35, 1'b0);
    cyc(6, 3, 0, 80, 0, 0, 0, 0, 1'b1, 80, 1'b0);
    cyc(7, 3, 0, 0, 0, 0, 0, 0, 1'b1, 36, 1'b0);
    cyc(7, 3, 0, 0, 0, 0, 0, 0, 1'b1, 36, 1'b0);

    // Asynchronous reset mid-wait after a CALL (state 5, retReg 37).
    cyc(6, 3, 0, 5, 0, 0, 0, 0, 1'b1, 5, 1'b0);
    nField = 3'd5; sField = 2'd0; invField = 1'b0; moc = 1'b0;
    #1;
    chk("pre_reset_waiting", int'(waiting), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_state", int'(currentState), 0);
    chk("async_reset_fault", int'(fault), 0);
    chk("async_reset_waiting", int'(waiting), 0);
    @(posedge clk);
    #1;
    chk("held_reset_state", int'(currentState), 0);
    #1;
    reset = 1'b0;
    m_st = 0; m_ret = 0; m_wc = 0;
    cyc(7, 3, 0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 127), $urandom_range(0, 127),
          ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 1),
          $urandom_range(0, 1));
    end

    // Let the monitor consume the final prediction.
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      chk("queue_drained", q.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_microprogram_sequencer
